// File: rtl/mips_alu_exec_stage.sv
// Two-stage execute pipeline around the combinational mipsALU.
// Stage 1 holds the ALU operands/control; stage 2 holds the ALU result for writeback.
module mips_alu_exec_stage #(
    parameter int WIDTH     = 8,
    parameter int BAD_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           aluop,
    input  logic [5:0]           funct,
    input  logic [WIDTH-1:0]     rs_val,
    input  logic [WIDTH-1:0]     rt_val,
    input  logic [WIDTH-1:0]     imm,
    input  logic                 alu_src,
    output logic [3:0]           alu_ctl,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 zero,
    output logic                 bad_op,
    output logic [BAD_CNT_W-1:0] bad_cnt
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_BAD = 4'b1111;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_bad_q,   s1_bad_d;
    logic [3:0]           alu_ctl_q,  alu_ctl_d;
    logic [WIDTH-1:0]     alu_a_q,    alu_a_d;
    logic [WIDTH-1:0]     alu_b_q,    alu_b_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     result_q,   result_d;
    logic                 zero_q,     zero_d;
    logic                 bad_op_q,   bad_op_d;
    logic [BAD_CNT_W-1:0] bad_cnt_q,  bad_cnt_d;

    logic [3:0] ctl_dec;
    logic       bad_dec;
    logic       s1_adv;
    logic       accept;

    always_comb begin
        ctl_dec = CTL_BAD;
        bad_dec = 1'b0;
        unique case (aluop)
            2'b00: ctl_dec = CTL_ADD;
            2'b01: ctl_dec = CTL_SUB;
            2'b11: ctl_dec = CTL_OR;
            default: begin
                unique case (funct)
                    6'b100000: ctl_dec = CTL_ADD;
                    6'b100010: ctl_dec = CTL_SUB;
                    6'b100100: ctl_dec = CTL_AND;
                    6'b100101: ctl_dec = CTL_OR;
                    6'b100111: ctl_dec = CTL_NOR;
                    6'b101010: ctl_dec = CTL_SLT;
                    default: begin
                        ctl_dec = CTL_BAD;
                        bad_dec = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Stage 1 may hand off whenever stage 2 is empty or draining this same edge.
    assign s1_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s1_adv;
    assign accept   = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bad_d   = s1_bad_q;
        alu_ctl_d  = alu_ctl_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        bad_cnt_d  = bad_cnt_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_bad_d   = bad_dec;
            alu_ctl_d  = ctl_dec;
            alu_a_d    = rs_val;
            alu_b_d    = alu_src ? imm : rt_val;
            if (bad_dec && (bad_cnt_q != {BAD_CNT_W{1'b1}}))
                bad_cnt_d = bad_cnt_q + 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Result fields hold their last value when the stage drains without refill.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        bad_op_d   = bad_op_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            result_d   = alu_out;
            zero_d     = alu_zero;
            bad_op_d   = s1_bad_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_bad_q   <= 1'b0;
            alu_ctl_q  <= CTL_BAD;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            bad_op_q   <= 1'b0;
            bad_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bad_q   <= s1_bad_d;
            alu_ctl_q  <= alu_ctl_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            bad_op_q   <= bad_op_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign alu_ctl   = alu_ctl_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign bad_op    = bad_op_q;
    assign bad_cnt   = bad_cnt_q;

endmodule

// File: tb/tb_mips_alu_exec_stage.sv
// Bench for mips_alu_exec_stage: an 8-bit ALU stands in for mipsALU, and a queue of
// instruction-level expected results tracks everything the pipeline accepts.
module tb_mips_alu_exec_stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] aluop;
    logic [5:0] funct;
    logic [7:0] rs_val, rt_val, imm;
    logic       alu_src;
    logic [3:0] alu_ctl;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       bad_op;
    logic [3:0] bad_cnt;

    int checks = 0;
    int errors = 0;

    mips_alu_exec_stage #(.WIDTH(8), .BAD_CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .alu_src(alu_src), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .bad_op(bad_op),
        .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational mipsALU.
    always_comb begin
        case (alu_ctl)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b0111: alu_out = (alu_a < alu_b) ? 8'd1 : 8'd0;
            4'b1100: alu_out = ~(alu_a | alu_b);
            default: alu_out = 8'd0;
        endcase
        alu_zero = (alu_out == 8'd0);
    end

    typedef struct {
        logic [7:0] r;
        logic       z;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   occ  = 0;
    int   mcnt = 0;
    logic [5:0] legal [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction semantics straight from the opcode table.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.b = 1'b0;
        case (op)
            2'd0: e.r = a + b;
            2'd1: e.r = a - b;
            2'd3: e.r = a | b;
            default: begin
                if (fn == 6'h20)      e.r = a + b;
                else if (fn == 6'h22) e.r = a - b;
                else if (fn == 6'h24) e.r = a & b;
                else if (fn == 6'h25) e.r = a | b;
                else if (fn == 6'h27) e.r = ~(a | b);
                else if (fn == 6'h2A) e.r = (a < b) ? 8'd1 : 8'd0;
                else begin
                    e.r = 8'd0;
                    e.b = 1'b1;
                end
            end
        endcase
        e.z = (e.r == 8'd0);
        return e;
    endfunction

    task automatic set_op(input logic v, input logic [1:0] op, input logic [5:0] fn,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] im,
                          input logic src);
        in_valid = v;
        aluop    = op;
        funct    = fn;
        rs_val   = a;
        rt_val   = b;
        imm      = im;
        alu_src  = src;
    endtask

    // One clock: check handshake/result at the falling edge, then advance past the rising edge.
    task automatic tick();
        exp_t e;
        logic fire, acc;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, (occ < 2) || out_ready});
        chk("bad_cnt", {28'd0, bad_cnt}, mcnt);
        fire = out_valid & out_ready;
        acc  = in_valid & in_ready;
        if (fire) begin
            if (q.size() == 0) begin
                chk("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                occ--;
                chk("result", {24'd0, result}, {24'd0, e.r});
                chk("zero", {31'd0, zero}, {31'd0, e.z});
                chk("bad_op", {31'd0, bad_op}, {31'd0, e.b});
            end
        end
        if (acc) begin
            e = model(aluop, funct, rs_val, alu_src ? imm : rt_val);
            q.push_back(e);
            occ++;
            if (e.b && mcnt < 15) mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && q.size() != 0; i++) tick();
        chk("drain_empty", q.size(), 32'd0);
    endtask

    logic [7:0] held_res, held_a;

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        set_op(1'b0, 2'd0, 6'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_ctl", {28'd0, alu_ctl}, 32'hF);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_bad_cnt", {28'd0, bad_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        tick();

        // add 5+3 with latency check
        set_op(1'b1, 2'd2, 6'h20, 8'd5, 8'd3, 8'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("lat_s1_only", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", {24'd0, result}, 32'd8);
        tick();

        set_op(1'b1, 2'd1, 6'h00, 8'd7, 8'd7, 8'd0, 1'b0);
        tick();
        set_op(1'b1, 2'd0, 6'h00, 8'd250, 8'd0, 8'd10, 1'b1);
        tick();
        set_op(1'b1, 2'd2, 6'h2A, 8'd3, 8'd9, 8'd0, 1'b0);
        tick();
        set_op(1'b1, 2'd2, 6'h27, 8'h0F, 8'hF0, 8'd0, 1'b0);
        tick();
        set_op(1'b1, 2'd3, 6'h00, 8'h11, 8'd0, 8'h22, 1'b1);
        tick();
        drain(10);

        // backpressure: two ops fill the pipe, third waits
        out_ready = 1'b0;
        set_op(1'b1, 2'd2, 6'h22, 8'd20, 8'd5, 8'd0, 1'b0);
        tick();
        set_op(1'b1, 2'd2, 6'h24, 8'hF3, 8'h3C, 8'd0, 1'b0);
        tick();
        set_op(1'b1, 2'd2, 6'h25, 8'h81, 8'h18, 8'd0, 1'b0);
        tick();
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        held_res = result;
        held_a   = alu_a;
        repeat (3) tick();
        chk("bp_result_hold", {24'd0, result}, {24'd0, held_res});
        chk("bp_alu_a_hold", {24'd0, alu_a}, {24'd0, held_a});
        chk("bp_queued", occ, 32'd2);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain(10);

        // illegal funct, bad_cnt saturation
        for (int i = 0; i < 20; i++) begin
            set_op(1'b1, 2'd2, 6'h3F, 8'($urandom), 8'($urandom), 8'd0, 1'b0);
            tick();
        end
        drain(10);
        chk("bad_cnt_sat", {28'd0, bad_cnt}, 32'd15);

        // reset with both stages full
        out_ready = 1'b0;
        set_op(1'b1, 2'd0, 6'h00, 8'd1, 8'd2, 8'd0, 1'b0);
        repeat (3) tick();
        chk("pre_rst_full", occ, 32'd2);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_bad_cnt", {28'd0, bad_cnt}, 32'd0);
        chk("mid_rst_result", {24'd0, result}, 32'd0);
        q.delete();
        occ  = 0;
        mcnt = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_out", {31'd0, out_valid}, 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
            set_op(1'($urandom_range(0, 3) != 0), op, fn, 8'($urandom), 8'($urandom),
                   8'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
